// File: rtl/ex_stage_pkg.sv
// Shared widths, stall polarity, divider state codes and ID->EX bus layout
// for the execute stage.
package ex_stage_pkg;

    localparam int STALL_WD     = 6;
    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 44;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_BUSY = 2'b01;
    localparam logic [1:0] DIV_DONE = 2'b10;

    // Bit positions inside the one-hot alu_op field (add is the MSB).
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    typedef enum logic [2:0] {
        LOP_NONE,
        LOP_DIV,
        LOP_DIVU,
        LOP_MFHI,
        LOP_MFLO
    } local_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    function automatic local_op_e decode_local(input logic [5:0] opcode, input logic [5:0] func);
        local_op_e op;
        op = LOP_NONE;
        if (opcode == 6'b0) begin
            case (func)
                FN_DIV:  op = LOP_DIV;
                FN_DIVU: op = LOP_DIVU;
                FN_MFHI: op = LOP_MFHI;
                FN_MFLO: op = LOP_MFLO;
                default: op = LOP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Data SRAM request bus driven by the execute stage.
interface ex_stage_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
    modport slave  (input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, 32 BUSY cycles,
// result held in DONE until the pipeline acknowledges it.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    input  logic        ack,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] sr_q, sr_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] raw_dividend_q, raw_dividend_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [32:0] trial;
    logic [31:0] a_mag, b_mag;

    assign a_mag = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign b_mag = (signed_op && divisor[31])  ? (~divisor  + 32'd1) : divisor;
    // Partial remainder with the next dividend bit shifted in, minus divisor.
    assign trial = sr_q[63:31] - {1'b0, divisor_q};

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sr_d           = sr_q;
        divisor_d      = divisor_q;
        raw_dividend_d = raw_dividend_q;
        neg_quot_d     = neg_quot_q;
        neg_rem_d      = neg_rem_q;
        div_zero_d     = div_zero_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d        = DIV_BUSY;
                    cnt_d          = 5'd0;
                    sr_d           = {32'b0, a_mag};
                    divisor_d      = b_mag;
                    raw_dividend_d = dividend;
                    neg_quot_d     = signed_op & (dividend[31] ^ divisor[31]);
                    neg_rem_d      = signed_op & dividend[31];
                    div_zero_d     = (divisor == 32'd0);
                end
            end
            DIV_BUSY: begin
                if (!trial[32]) sr_d = {trial[31:0], sr_q[30:0], 1'b1};
                else            sr_d = {sr_q[62:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (ack) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= DIV_IDLE;
            cnt_q          <= 5'd0;
            sr_q           <= 64'd0;
            divisor_q      <= 32'd0;
            raw_dividend_q <= 32'd0;
            neg_quot_q     <= 1'b0;
            neg_rem_q      <= 1'b0;
            div_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sr_q           <= sr_d;
            divisor_q      <= divisor_d;
            raw_dividend_q <= raw_dividend_d;
            neg_quot_q     <= neg_quot_d;
            neg_rem_q      <= neg_rem_d;
            div_zero_q     <= div_zero_d;
        end
    end

    assign busy = (state_q != DIV_IDLE);
    assign done = (state_q == DIV_DONE);

    assign quotient  = div_zero_q ? 32'hFFFF_FFFF
                     : (neg_quot_q ? (~sr_q[31:0] + 32'd1) : sr_q[31:0]);
    assign remainder = div_zero_q ? raw_dividend_q
                     : (neg_rem_q ? (~sr_q[63:32] + 32'd1) : sr_q[63:32]);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: EX pipeline register, operand muxes, one-hot ALU,
// data SRAM request, HI/LO registers and the iterative divider.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    ex_stage_if.master              sram,
    output logic                    stallreq_for_ex
);

    id_ex_t      ex_q, ex_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] src1, src2, imm_sext, imm_zext, alu_res, ex_result;
    logic [31:0] sll_res, srl_res, sra_res;
    logic [4:0]  shamt;
    local_op_e   local_op;
    logic        is_div, div_busy, div_done, div_ack;
    logic [31:0] div_quot, div_rem;
    logic        unused_inst_bits;

    always_comb begin
        ex_d = ex_q;
        if (stall[2] == STOP && stall[3] == NO_STOP) ex_d = '0;
        else if (stall[2] == NO_STOP)                ex_d = id_ex_t'(id_to_ex_bus);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign imm_sext = {{16{ex_q.inst[15]}}, ex_q.inst[15:0]};
    assign imm_zext = {16'b0, ex_q.inst[15:0]};

    assign src1 = ({32{ex_q.sel_alu_src1[0]}} & ex_q.rdata1)
                | ({32{ex_q.sel_alu_src1[1]}} & ex_q.pc)
                | ({32{ex_q.sel_alu_src1[2]}} & {27'b0, ex_q.inst[10:6]});

    assign src2 = ({32{ex_q.sel_alu_src2[0]}} & ex_q.rdata2)
                | ({32{ex_q.sel_alu_src2[1]}} & imm_sext)
                | ({32{ex_q.sel_alu_src2[2]}} & 32'd8)
                | ({32{ex_q.sel_alu_src2[3]}} & imm_zext);

    assign shamt   = src1[4:0];
    assign sll_res = src2 << shamt;
    assign srl_res = src2 >> shamt;
    assign sra_res = $signed(src2) >>> shamt;

    assign alu_res = ({32{ex_q.alu_op[ALU_ADD]}}  & (src1 + src2))
                   | ({32{ex_q.alu_op[ALU_SUB]}}  & (src1 - src2))
                   | ({32{ex_q.alu_op[ALU_SLT]}}  & {31'b0, $signed(src1) < $signed(src2)})
                   | ({32{ex_q.alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
                   | ({32{ex_q.alu_op[ALU_AND]}}  & (src1 & src2))
                   | ({32{ex_q.alu_op[ALU_NOR]}}  & ~(src1 | src2))
                   | ({32{ex_q.alu_op[ALU_OR]}}   & (src1 | src2))
                   | ({32{ex_q.alu_op[ALU_XOR]}}  & (src1 ^ src2))
                   | ({32{ex_q.alu_op[ALU_SLL]}}  & sll_res)
                   | ({32{ex_q.alu_op[ALU_SRL]}}  & srl_res)
                   | ({32{ex_q.alu_op[ALU_SRA]}}  & sra_res)
                   | ({32{ex_q.alu_op[ALU_LUI]}}  & {src2[15:0], 16'b0});

    assign local_op = decode_local(ex_q.inst[31:26], ex_q.inst[5:0]);
    assign is_div   = (local_op == LOP_DIV) || (local_op == LOP_DIVU);
    assign div_ack  = (stall[3] == NO_STOP);

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div && !div_busy),
        .signed_op (local_op == LOP_DIV),
        .dividend  (ex_q.rdata1),
        .divisor   (ex_q.rdata2),
        .busy      (div_busy),
        .done      (div_done),
        .ack       (div_ack),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // HI/LO change only when the finished division is released from EX.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done && div_ack) begin
            hi_d = div_rem;
            lo_d = div_quot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        case (local_op)
            LOP_MFHI: ex_result = hi_q;
            LOP_MFLO: ex_result = lo_q;
            default:  ex_result = alu_res;
        endcase
    end

    assign stallreq_for_ex = is_div && !div_done;

    assign ex_to_mem_bus = {ex_q.pc, ex_q.data_ram_en, ex_q.data_ram_wen, ex_q.sel_rf_res,
                            ex_q.rf_we, ex_q.rf_waddr, ex_result};
    assign ex_to_id_bus  = {ex_q.rf_we, ex_q.rf_waddr, ex_result, ex_q.inst[31:26]};

    assign sram.data_sram_en    = ex_q.data_ram_en;
    assign sram.data_sram_wen   = ex_q.data_ram_wen;
    assign sram.data_sram_addr  = ex_result;
    assign sram.data_sram_wdata = ex_q.rdata2;

    assign unused_inst_bits = ^ex_q.inst[25:16];

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU ops, store path, divider timing,
// reset mid-division and bubble insertion.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_WD-1:0]     stall;
    logic [ID_TO_EX_WD-1:0]  id_bus;
    logic [EX_TO_MEM_WD-1:0] mem_bus;
    logic [EX_TO_ID_WD-1:0]  fwd_bus;
    logic                    stallreq;

    ex_stage_if sram_if ();

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (mem_bus),
        .ex_to_id_bus    (fwd_bus),
        .sram            (sram_if),
        .stallreq_for_ex (stallreq)
    );

    always #5 clk = ~clk;

    int test_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [11:0] aop(input int b);
        logic [11:0] v;
        v = 12'd0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] func, input logic [4:0] sa);
        return {6'b0, 5'd1, 5'd2, 5'd3, sa, func};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic id_ex_t mk(input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                                  input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                                  input logic we);
        id_ex_t v;
        v = '0;
        v.pc           = 32'h0040_0000;
        v.inst         = inst;
        v.alu_op       = op;
        v.sel_alu_src1 = s1;
        v.sel_alu_src2 = s2;
        v.rf_we        = we;
        v.rf_waddr     = 5'd3;
        v.rdata1       = r1;
        v.rdata2       = r2;
        return v;
    endfunction

    task automatic load(input id_ex_t v);
        id_bus = v;
        stall  = 6'b000000;
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input id_ex_t v, input logic [31:0] exp);
        load(v);
        check(tag, mem_bus[31:0], exp);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q_exp, input logic [31:0] r_exp);
        int cyc;
        load(mk(12'd0, 3'b001, 4'b0001, rtype(sgn ? FN_DIV : FN_DIVU, 5'd0), a, b, 1'b0));
        cyc = 0;
        while (stallreq === 1'b1 && cyc < 100) begin
            stall  = 6'b001111;
            id_bus = mk(12'd0, 3'b000, 4'b0000, rtype(FN_MFLO, 5'd0), 32'd0, 32'd0, 1'b1);
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " stallreq cycles"}, 32'(cyc), 32'd33);
        load(mk(12'd0, 3'b000, 4'b0000, rtype(FN_MFLO, 5'd0), 32'd0, 32'd0, 1'b1));
        check({tag, " mflo"}, mem_bus[31:0], q_exp);
        load(mk(12'd0, 3'b000, 4'b0000, rtype(FN_MFHI, 5'd0), 32'd0, 32'd0, 1'b1));
        check({tag, " mfhi"}, mem_bus[31:0], r_exp);
    endtask

    initial begin
        id_ex_t v;
        rst    = 1'b1;
        stall  = 6'b000000;
        id_bus = mk(aop(ALU_ADD), 3'b001, 4'b0001, 32'h1234_5678, 32'h1, 32'h2, 1'b1);
        #1;
        check("reset ex_result", mem_bus[31:0], 32'd0);
        check("reset stallreq", {31'd0, stallreq}, 32'd0);
        @(posedge clk);
        #1;
        check("reset after edge rf_we", {31'd0, fwd_bus[43]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        v = mk(aop(ALU_ADD), 3'b001, 4'b0010, itype(6'b001001, 16'h0001), 32'h7FFF_FFFF, 32'd0, 1'b1);
        run_alu("addiu wrap", v, 32'h8000_0000);
        check("addiu fwd rf_we", {31'd0, fwd_bus[43]}, 32'd1);

        v = mk(aop(ALU_ADD), 3'b001, 4'b0010, itype(6'b101011, 16'hFFFC), 32'h1000_0000, 32'hDEAD_BEEF, 1'b0);
        v.data_ram_en  = 1'b1;
        v.data_ram_wen = 4'hF;
        load(v);
        check("sw en", {31'd0, sram_if.data_sram_en}, 32'd1);
        check("sw wen", {28'd0, sram_if.data_sram_wen}, 32'h0000_000F);
        check("sw addr", sram_if.data_sram_addr, 32'h0FFF_FFFC);
        check("sw wdata", sram_if.data_sram_wdata, 32'hDEAD_BEEF);

        run_alu("sub wrap", mk(aop(ALU_SUB), 3'b001, 4'b0001, rtype(6'b100011, 5'd0), 32'd0, 32'd1, 1'b1), 32'hFFFF_FFFF);
        run_alu("slt", mk(aop(ALU_SLT), 3'b001, 4'b0001, rtype(6'b101010, 5'd0), 32'hFFFF_FFFF, 32'd1, 1'b1), 32'd1);
        run_alu("sltu", mk(aop(ALU_SLTU), 3'b001, 4'b0001, rtype(6'b101011, 5'd0), 32'hFFFF_FFFF, 32'd1, 1'b1), 32'd0);
        run_alu("and", mk(aop(ALU_AND), 3'b001, 4'b0001, rtype(6'b100100, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1), 32'hF000_F000);
        run_alu("nor", mk(aop(ALU_NOR), 3'b001, 4'b0001, rtype(6'b100111, 5'd0), 32'h0F0F_0000, 32'h0000_F0F0, 1'b1), 32'hF0F0_0F0F);
        run_alu("or", mk(aop(ALU_OR), 3'b001, 4'b0001, rtype(6'b100101, 5'd0), 32'h0F0F_0000, 32'h0000_F0F0, 1'b1), 32'h0F0F_F0F0);
        run_alu("xor", mk(aop(ALU_XOR), 3'b001, 4'b0001, rtype(6'b100110, 5'd0), 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1), 32'hF0F0_F0F0);
        run_alu("sll", mk(aop(ALU_SLL), 3'b100, 4'b0001, rtype(6'b000000, 5'd4), 32'd0, 32'd1, 1'b1), 32'd16);
        run_alu("srl", mk(aop(ALU_SRL), 3'b100, 4'b0001, rtype(6'b000010, 5'd4), 32'd0, 32'h8000_0000, 1'b1), 32'h0800_0000);
        run_alu("sra", mk(aop(ALU_SRA), 3'b100, 4'b0001, rtype(6'b000011, 5'd4), 32'd0, 32'h8000_0000, 1'b1), 32'hF800_0000);
        run_alu("lui", mk(aop(ALU_LUI), 3'b000, 4'b1000, itype(6'b001111, 16'h1234), 32'd0, 32'd0, 1'b1), 32'h1234_0000);
        run_alu("pc+8", mk(aop(ALU_ADD), 3'b010, 4'b0100, itype(6'b000011, 16'h0000), 32'd0, 32'd0, 1'b1), 32'h0040_0008);
        run_alu("ori zext", mk(aop(ALU_OR), 3'b001, 4'b1000, itype(6'b001101, 16'hFFFC), 32'd0, 32'd0, 1'b1), 32'h0000_FFFC);

        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("divu by zero", 1'b0, 32'h0000_0064, 32'd0, 32'hFFFF_FFFF, 32'h0000_0064);

        // Reset while the divider is at BUSY count 10.
        load(mk(12'd0, 3'b001, 4'b0001, rtype(FN_DIV, 5'd0), 32'd100, 32'd7, 1'b0));
        stall = 6'b001111;
        repeat (11) @(posedge clk);
        #1;
        check("mid-div stallreq", {31'd0, stallreq}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst stallreq", {31'd0, stallreq}, 32'd0);
        check("rst ex_result", mem_bus[31:0], 32'd0);
        check("rst mem pc", mem_bus[75:44], 32'd0);
        check("rst sram en", {31'd0, sram_if.data_sram_en}, 32'd0);
        check("rst sram wdata", sram_if.data_sram_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load(mk(12'd0, 3'b000, 4'b0000, rtype(FN_MFHI, 5'd0), 32'd0, 32'd0, 1'b1));
        check("rst hi cleared", mem_bus[31:0], 32'd0);
        load(mk(12'd0, 3'b000, 4'b0000, rtype(FN_MFLO, 5'd0), 32'd0, 32'd0, 1'b1));
        check("rst lo cleared", mem_bus[31:0], 32'd0);

        // Bubble: a div waiting in ID must not reach EX.
        run_alu("pre-bubble", mk(aop(ALU_ADD), 3'b001, 4'b0010, itype(6'b001001, 16'h0005), 32'd1, 32'd0, 1'b1), 32'd6);
        id_bus = mk(12'd0, 3'b001, 4'b0001, rtype(FN_DIV, 5'd0), 32'd100, 32'd7, 1'b1);
        id_bus[ID_TO_EX_WD-1-32-32-12-3-4] = 1'b1;
        stall = 6'b000111;
        @(posedge clk);
        #1;
        check("bubble rf_we", {31'd0, fwd_bus[43]}, 32'd0);
        check("bubble sram en", {31'd0, sram_if.data_sram_en}, 32'd0);
        check("bubble stallreq", {31'd0, stallreq}, 32'd0);
        stall = 6'b001111;
        @(posedge clk);
        #1;
        check("bubble hold stallreq", {31'd0, stallreq}, 32'd0);
        check("bubble hold ex_result", mem_bus[31:0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It sits directly downstream of the decode stage and registers `id_to_ex_bus`. It evaluates the ALU operation, forms load/store addresses, and drives the data SRAM. It owns the HI/LO registers and an iterative 32-cycle divider. It feeds the memory stage and returns a forwarding/load-use bus to decode.

## Interface
Parameters: none. Widths come from `lib/defines.vh`.
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `stall`  in  `StallBus`  global stall vector; bit 2 = ID, bit 3 = EX, bit 4 = MEM
- `id_to_ex_bus`  in  `ID_TO_EX_WD` (159)  {pc, inst, alu_op[11:0], sel_alu_src1[2:0], sel_alu_src2[3:0], data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1, rdata2}
- `ex_to_mem_bus`  out  `EX_TO_MEM_WD` (76)  {pc, data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result}
- `ex_to_id_bus`  out  `EX_TO_ID_WD` (44)  {rf_we, rf_waddr, ex_result, ex_op = inst[31:26]}
- `data_sram_en`  out  1  data SRAM enable
- `data_sram_wen`  out  4  byte write enables
- `data_sram_addr`  out  32  byte address
- `data_sram_wdata`  out  32  store data
- `stallreq_for_ex`  out  1  divider busy; requests stall of EX and earlier stages

## Operation
- **Input register:**
  - `rst` → all zero (bubble).
  - `stall[2]`=Stop and `stall[3]`=NoStop → load zero (bubble).
  - `stall[2]`=NoStop → load `id_to_ex_bus`.
  - Otherwise → hold.
- **Operand src1:** one-hot select:
  - [0] rdata1
  - [1] pc
  - [2] {27'b0, inst[10:6]}
- **Operand src2:** one-hot select:
  - [0] rdata2
  - [1] sign-extended inst[15:0]
  - [2] 32'd8
  - [3] zero-extended inst[15:0]
- **ALU:** one-hot `alu_op` order is add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - All arithmetic is 32-bit wrap; no overflow trap.
  - sll/srl/sra shift src2 by src1[4:0].
  - lui = {src2[15:0], 16'b0}.
  - slt is signed and sltu is unsigned; both give a 0/1 result.
- **Local decode** when inst[31:26]=0:
  - func 011010 = div
  - func 011011 = divu
  - func 010000 = mfhi
  - func 010010 = mflo
- **ex_result:** HI for mfhi, LO for mflo, otherwise the ALU result. Decode is responsible for asserting `rf_we` and dest rd for mfhi/mflo.
- **Data SRAM:** driven combinationally from the EX register.
  - en = data_ram_en
  - wen = data_ram_wen
  - addr = ex_result
  - wdata = rdata2
  - A bubble gives all zero.
- **Divider FSM** (sub-module `div_iter`), states IDLE, BUSY, DONE:
  - IDLE, div/divu in EX → BUSY, count=0. Operands are latched: magnitudes for div, raw values for divu.
  - BUSY → one restoring step per cycle. When count=31 → DONE.
  - DONE and `stall[3]`=NoStop → write LO=quotient, HI=remainder, then → IDLE.
  - DONE and `stall[3]`=Stop → hold in DONE.
- **Signed fix-up:** quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- **Divide by zero:** same latency; LO=32'hFFFF_FFFF, HI=rs, for both div and divu.
- **stallreq_for_ex:** = (div/divu in EX and state≠DONE).
- **HI/LO:** reset to 0 and written only at DONE. A bubble never starts the divider.

## Timing
- All outputs are combinational from the EX register and FSM. ALU ops, loads and stores have latency 1.
- div/divu occupies EX for 34 cycles: 1 IDLE cycle, 32 BUSY cycles, 1 DONE cycle.
  - `stallreq_for_ex` is high for the first 33 of those cycles and low in DONE.
- A subsequent mfhi/mflo that enters EX on the edge after DONE reads the new value.
- Asynchronous `rst` mid-division → IDLE, count=0, HI/LO=0, EX register zero, `stallreq_for_ex`=0 immediately.
- Back-to-back divs: the second starts from IDLE after the first's DONE edge. There is no overlap.

## Structure
- Add to `lib/defines.vh`:
  - `EX_TO_MEM_WD`=76
  - `EX_TO_ID_WD`=44
  - divider state encodings (IDLE/BUSY/DONE, 2 bits)
- The existing `Stop`/`NoStop` and `StallBus` are used unchanged.
- One sub-module, `div_iter`:
  - Ports: clk, rst, start, signed_op, dividend, divisor, busy, done, ack, quotient, remainder.
  - Contents: the FSM, the 5-bit counter and 64-bit shift register.
- The ALU stays inline.

## Test plan
- **addiu:** rs=32'h7FFF_FFFF, imm=16'h0001 → ex_result=32'h8000_0000 one cycle after load; ex_to_id_bus rf_we=1.
- **sw:** rs=32'h1000_0000, imm=16'hFFFC, rt=32'hDEAD_BEEF → data_sram_en=1, wen=4'hF, addr=32'h0FFF_FFFC, wdata=32'hDEAD_BEEF.
- **div then mflo/mfhi:**
  - div rs=-7, rt=2 → stallreq_for_ex high 33 cycles, then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
  - Following mflo → ex_result=32'hFFFF_FFFD.
- **divu by zero:** rs=32'h0000_0064, rt=0 → 34-cycle occupancy, LO=32'hFFFF_FFFF, HI=32'h64.
- **rst mid-division:** assert rst at BUSY count 10 → stallreq_for_ex=0 and all outputs zero before the next edge; HI/LO=0.
- **Bubble insertion:** stall=6'b000111 for one cycle → EX loads zero; data_sram_en=0, rf_we=0; divider stays IDLE.
